// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART receiver: serial line in, parallel byte plus status out.
// The receiver is the master of the parallel side; the consumer sees it through slave.
interface uart_rx_if;
  logic       rx;
  logic [7:0] out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output out, valid, parity_err, frame_err, busy
  );

  modport slave (
    output rx,
    input  out, valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, even parity, two stop bits.
// Mid-bit sampling off a bit-period counter; one-cycle valid strobe per frame.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    idx, idx_next;
  logic [7:0]    shift, shift_next;
  logic          par_bit, par_bit_next;
  logic          stop1, stop1_next;
  logic          stop2, stop2_next;
  logic [7:0]    out_q, out_next;
  logic          valid_q, valid_next;
  logic          perr_q, perr_next;
  logic          ferr_q, ferr_next;
  logic          busy_q, busy_next;
  logic          armed, armed_next;
  logic          rx_m, rx_s;

  // Two-flop synchroniser; resets to the idle-high line level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      stop1   <= 1'b0;
      stop2   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      armed   <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      shift   <= shift_next;
      par_bit <= par_bit_next;
      stop1   <= stop1_next;
      stop2   <= stop2_next;
      out_q   <= out_next;
      valid_q <= valid_next;
      perr_q  <= perr_next;
      ferr_q  <= ferr_next;
      busy_q  <= busy_next;
      armed   <= armed_next;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CW'(1);
    idx_next     = idx;
    shift_next   = shift;
    par_bit_next = par_bit;
    stop1_next   = stop1;
    stop2_next   = stop2;
    out_next     = out_q;
    valid_next   = 1'b0;
    perr_next    = perr_q;
    ferr_next    = ferr_q;
    busy_next    = busy_q;
    armed_next   = armed;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!armed && rx_s) armed_next = 1'b1;
        // A rejected glitch leaves busy set; it clears here one cycle later.
        if (armed && !rx_s) begin
          state_next = START;
          busy_next  = 1'b1;
        end else begin
          busy_next  = 1'b0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_next        = '0;
          shift_next[idx] = rx_s;
          if (idx == 3'd7) state_next = PARITY;
          else             idx_next   = idx + 3'd1;
        end
      end
      PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_next     = '0;
          par_bit_next = rx_s;
          state_next   = STOP1;
        end
      end
      STOP1: begin
        if (cnt == FULL_M1) begin
          cnt_next   = '0;
          stop1_next = rx_s;
          state_next = STOP2;
        end
      end
      STOP2: begin
        if (cnt == FULL_M1) begin
          cnt_next   = '0;
          stop2_next = rx_s;
          state_next = DONE;
        end
      end
      DONE: begin
        cnt_next   = '0;
        out_next   = shift;
        perr_next  = par_bit != ^shift;
        ferr_next  = !(stop1 & stop2);
        valid_next = 1'b1;
        busy_next  = 1'b0;
        // A framing error disarms until the line is seen high, so a break cannot retrigger.
        armed_next = stop1 & stop2;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.out        = out_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: frames, back-to-back timing,
// error flags, break handling, glitch rejection and asynchronous reset.
module tb_uart_rx;
  localparam int N = 16;
  localparam int H = N / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus_if ();

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs each valid pulse and tracks busy low runs and falling edges.
  int         vcount = 0;
  logic [7:0] vout[0:31];
  int         vcyc[0:31];
  logic       busy_seen = 1'b0;
  logic       busy_d = 1'b0;
  int         low_run = 0;
  int         last_low_run = 0;
  int         busy_fall_cyc = 0;

  always @(negedge clk) begin
    if (bus_if.valid === 1'b1) begin
      if (vcount < 32) begin
        vout[vcount] = bus_if.out;
        vcyc[vcount] = cyc;
      end
      vcount++;
    end
    if (bus_if.busy === 1'b1) begin
      busy_seen = 1'b1;
      if (!busy_d) begin
        last_low_run = low_run;
        low_run      = 0;
      end
    end else begin
      low_run++;
      if (busy_d) busy_fall_cyc = cyc;
    end
    busy_d = (bus_if.busy === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int len);
    bus_if.rx = b;
    repeat (len) @(negedge clk);
  endtask

  task automatic idle(input int len);
    send_bit(1'b1, len);
  endtask

  // Called at a negedge; returns the cycle count at which the start bit was driven.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                            input logic s2, input int s2_len, output int fall);
    fall = cyc;
    send_bit(1'b0, N);
    for (int i = 0; i < 8; i++) send_bit(d[i], N);
    send_bit(p, N);
    send_bit(s1, N);
    send_bit(s2, s2_len);
  endtask

  initial begin
    int f, f1, f2, base;
    logic [7:0] b;

    bus_if.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out", bus_if.out, 8'h00);
    check("rst_valid", bus_if.valid, 1'b0);
    check("rst_perr", bus_if.parity_err, 1'b0);
    check("rst_ferr", bus_if.frame_err, 1'b0);
    check("rst_busy", bus_if.busy, 1'b0);

    rst = 1'b0;
    busy_seen = 1'b0;
    idle(100);
    check("idle_busy_seen", busy_seen, 1'b0);
    check("idle_vcount", vcount, 0);
    check("idle_out", bus_if.out, 8'h00);

    // Single frame 0xB2: four ones, parity 0. t0 = fall+3, valid after t0+H+11N+1.
    send_frame(8'hB2, 1'b0, 1'b1, 1'b1, N, f);
    idle(4);
    check("single_vcount", vcount, 1);
    check("single_out", vout[0], 8'hB2);
    check("single_perr", bus_if.parity_err, 1'b0);
    check("single_ferr", bus_if.frame_err, 1'b0);
    check("single_busy", bus_if.busy, 1'b0);
    check("single_latency", vcyc[0] - f, 3 + H + 11 * N + 1);

    // Back-to-back full-length frames: valids 12N apart, busy low H-1 cycles between.
    base = vcount;
    send_frame(8'hB2, 1'b0, 1'b1, 1'b1, N, f1);
    send_frame(8'h26, 1'b1, 1'b1, 1'b1, N, f2);
    idle(4);
    check("b2b_vcount", vcount - base, 2);
    check("b2b_out0", vout[base], 8'hB2);
    check("b2b_out1", vout[base + 1], 8'h26);
    check("b2b_spacing", vcyc[base + 1] - vcyc[base], 12 * N);
    check("b2b_busy_gap", last_low_run, H - 1);
    check("b2b_perr", bus_if.parity_err, 1'b0);

    // Stop2 cut to H+2 cycles: next start lands the cycle after DONE.
    base = vcount;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, H + 2, f1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, N, f2);
    idle(4);
    check("tight_vcount", vcount - base, 2);
    check("tight_busy_gap", last_low_run, 1);
    check("tight_out1", vout[base + 1], 8'h81);

    // Parity error: 0x26 needs parity 1.
    send_frame(8'h26, 1'b0, 1'b1, 1'b1, N, f);
    idle(4);
    check("perr_out", bus_if.out, 8'h26);
    check("perr_flag", bus_if.parity_err, 1'b1);
    check("perr_ferr", bus_if.frame_err, 1'b0);

    // Stop2 = 0 then a 40-bit break: one errored frame, no retrigger.
    base = vcount;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, N, f);
    send_bit(1'b0, 40 * N);
    check("ferr_vcount", vcount - base, 1);
    check("ferr_flag", bus_if.frame_err, 1'b1);
    check("ferr_perr", bus_if.parity_err, 1'b0);
    check("ferr_out", bus_if.out, 8'h5A);
    check("break_busy", bus_if.busy, 1'b0);
    idle(2 * N);
    check("break_release_vcount", vcount - base, 1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, N, f);
    idle(4);
    check("rearm_vcount", vcount - base, 2);
    check("rearm_out", bus_if.out, 8'h81);
    check("rearm_ferr", bus_if.frame_err, 1'b0);

    // Glitch: 5 low cycles. busy falls at t0+H+1 = fall+12.
    base = vcount;
    busy_seen = 1'b0;
    f = cyc;
    send_bit(1'b0, 5);
    idle(3 * N);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy", bus_if.busy, 1'b0);
    check("glitch_vcount", vcount - base, 0);
    check("glitch_out", bus_if.out, 8'h81);
    check("glitch_busy_fall", busy_fall_cyc - f, 3 + H + 1);

    // Reset in the middle of data[3] of a 0xB2 frame.
    b = 8'hB2;
    send_bit(1'b0, N);
    for (int i = 0; i < 3; i++) send_bit(b[i], N);
    send_bit(b[3], H);
    check("mid_busy_before", bus_if.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_out", bus_if.out, 8'h00);
    check("mid_rst_busy", bus_if.busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = vcount;
    idle(N);
    send_frame(8'h26, 1'b1, 1'b1, 1'b1, N, f);
    idle(2 * N);
    check("mid_vcount", vcount - base, 1);
    check("mid_out", bus_if.out, 8'h26);
    check("mid_perr", bus_if.parity_err, 1'b0);
    check("mid_ferr", bus_if.frame_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
